// File: rtl/cic_pkg.sv
// Shared CIC helpers: internal width, power-of-two check and scaling shift amounts.
// Used by both the interpolator and the decimator.
package cic_pkg;

    typedef enum logic {
        SHIFT_LEFT,
        SHIFT_RIGHT
    } cic_shift_dir_e;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic int cic_log2(input int r);
        return $clog2(r);
    endfunction

    function automatic int cic_width(input int in_w, input int n, input int r);
        return in_w + n * cic_log2(r) + 1;
    endfunction

    // Removes the R^(N-1) DC gain of a zero-stuffing interpolator.
    function automatic int cic_scale_shift(input int n, input int r);
        return (n - 1) * cic_log2(r);
    endfunction

    function automatic cic_shift_dir_e cic_out_dir(input int in_w, input int out_w);
        return (out_w >= in_w) ? SHIFT_LEFT : SHIFT_RIGHT;
    endfunction

    function automatic int cic_out_shift(input int in_w, input int out_w);
        return (out_w >= in_w) ? (out_w - in_w) : (in_w - out_w);
    endfunction

endpackage

// File: rtl/cic_integrator_stage.sv
// One wrapping W-bit accumulator of the CIC integrator cascade, updated every clk.
module cic_integrator_stage
    import cic_pkg::*;
#(
    parameter int W = 19
) (
    input  logic                clk_i,
    input  logic                clr_i,
    input  logic signed [W-1:0] din_i,
    output logic signed [W-1:0] acc_o
);

    logic signed [W-1:0] acc_q;
    logic signed [W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q + din_i;
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/cic_interpolator.sv
// N-stage CIC interpolator by R: comb chain at the strobe rate, zero-stuffing,
// N full-rate integrators, then fixed shift scaling to unity DC gain.
module cic_interpolator
    import cic_pkg::*;
#(
    parameter int N            = 2,
    parameter int R            = 16,
    parameter int INPUT_WIDTH  = 14,
    parameter int OUTPUT_WIDTH = 14
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [INPUT_WIDTH-1:0]  in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic signed [OUTPUT_WIDTH-1:0] out_data,
    output logic                           out_valid,
    output logic                           underflow
);

    localparam int L     = cic_log2(R);
    localparam int W     = cic_width(INPUT_WIDTH, N, R);
    localparam int SCALE = cic_scale_shift(N, R);
    localparam int OSH   = cic_out_shift(INPUT_WIDTH, OUTPUT_WIDTH);
    localparam int WE    = W + OUTPUT_WIDTH;
    localparam int VLEN  = 2 * N + 1;
    localparam cic_shift_dir_e OUT_DIR = cic_out_dir(INPUT_WIDTH, OUTPUT_WIDTH);

    if (!is_pow2(R) || (R < 2) || (N < 1)) begin : g_bad_params
        $error("cic_interpolator: R must be a power of two >= 2 and N must be >= 1");
    end

    logic [L-1:0]                   phase_q, phase_d;
    logic                           underflow_q, underflow_d;
    logic [VLEN-1:0]                valid_sr_q, valid_sr_d;
    logic signed [OUTPUT_WIDTH-1:0] out_q, out_d;
    logic                           strobe;
    logic signed [W-1:0]            x_in;
    logic signed [WE-1:0]           acc_ext;

    logic signed [W-1:0] comb_y   [0:N];
    logic                comb_en  [0:N];
    logic signed [W-1:0] integ_in [0:N];

    assign strobe   = (phase_q == '0) && !rst;
    assign x_in     = in_valid ? W'(in_data) : '0;
    assign in_ready = strobe;

    assign comb_y[0]  = x_in;
    assign comb_en[0] = strobe;

    // Each comb stage fires once per input sample, one cycle after its predecessor.
    for (genvar k = 1; k <= N; k++) begin : g_comb
        logic signed [W-1:0] y_q;
        logic signed [W-1:0] dly_q;
        logic                en_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                y_q   <= '0;
                dly_q <= '0;
                en_q  <= 1'b0;
            end else begin
                en_q <= comb_en[k-1];
                if (comb_en[k-1]) begin
                    y_q   <= comb_y[k-1] - dly_q;
                    dly_q <= comb_y[k-1];
                end
            end
        end

        assign comb_y[k]  = y_q;
        assign comb_en[k] = en_q;
    end

    // Zero-stuffing: the comb result enters the integrators only on its valid cycle.
    assign integ_in[0] = comb_en[N] ? comb_y[N] : '0;

    for (genvar k = 1; k <= N; k++) begin : g_integ
        cic_integrator_stage #(
            .W(W)
        ) u_integ (
            .clk_i (clk),
            .clr_i (rst),
            .din_i (integ_in[k-1]),
            .acc_o (integ_in[k])
        );
    end

    assign acc_ext = WE'(integ_in[N]);

    always_comb begin
        phase_d     = phase_q + L'(1);
        underflow_d = underflow_q | (strobe & ~in_valid);
        valid_sr_d  = {valid_sr_q[VLEN-2:0], 1'b1};
        if (OUT_DIR == SHIFT_LEFT) begin
            out_d = OUTPUT_WIDTH'((acc_ext >>> SCALE) <<< OSH);
        end else begin
            out_d = OUTPUT_WIDTH'(acc_ext >>> (SCALE + OSH));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= '0;
            underflow_q <= 1'b0;
            valid_sr_q  <= '0;
            out_q       <= '0;
        end else begin
            phase_q     <= phase_d;
            underflow_q <= underflow_d;
            valid_sr_q  <= valid_sr_d;
            out_q       <= out_d;
        end
    end

    assign out_data  = out_q;
    assign out_valid = valid_sr_q[VLEN-1];
    assign underflow = underflow_q;

endmodule
